// File: rtl/rotor_stage.sv
// Pipelined Enigma rotor stage: forward/inverse substitution through a loadable
// wiring table, stepping position with notch carry. Ring setting via ROTOR_RING_EN.
module rotor_stage #(
    parameter int N_SYM = 26,
    parameter int SW    = 5,
    parameter int NOTCH = 4
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          in_valid,
    input  logic [SW-1:0] in_sym,
    input  logic          in_dir,
    output logic          out_valid,
    output logic [SW-1:0] out_sym,
    output logic          out_err,
    input  logic          step,
    input  logic          pos_load,
    input  logic [SW-1:0] pos_val,
    output logic [SW-1:0] pos,
    output logic          carry,
    input  logic          wr_en,
    input  logic [SW-1:0] wr_addr,
`ifdef ROTOR_RING_EN
    input  logic [SW-1:0] ring,
`endif
    input  logic [SW-1:0] wr_data
);

    localparam logic [SW-1:0] NS      = SW'(N_SYM);
    localparam logic [SW-1:0] LAST    = SW'(N_SYM - 1);
    localparam logic [SW-1:0] NOTCH_P = SW'(NOTCH);
    localparam logic [SW:0]   NW      = (SW + 1)'(N_SYM);

    // Operands are always < N_SYM, so one conditional correction suffices.
    function automatic logic [SW-1:0] add_mod(input logic [SW-1:0] a, input logic [SW-1:0] b);
        logic [SW:0] s;
        s = {1'b0, a} + {1'b0, b};
        if (s >= NW) s = s - NW;
        return s[SW-1:0];
    endfunction

    function automatic logic [SW-1:0] sub_mod(input logic [SW-1:0] a, input logic [SW-1:0] b);
        logic [SW:0] s;
        s = {1'b0, a} - {1'b0, b};
        if (a < b) s = s + NW;
        return s[SW-1:0];
    endfunction

    logic [SW-1:0] fwd_tbl [N_SYM];
    logic [SW-1:0] inv_tbl [N_SYM];

    // No backpressure: every item with in_valid high emerges exactly two cycles
    // later with out_valid high; idle cycles travel through as bubbles.
    logic          s1_valid, s1_err, s1_dir;
    logic [SW-1:0] s1_c, s1_pos;
`ifdef ROTOR_RING_EN
    logic [SW-1:0] s1_ring;
`endif

    logic          in_ok;
    logic [SW-1:0] c_d;
    logic [SW-1:0] w_s2, o_s2, sym_d;

    always_comb begin
        in_ok = (in_sym != '0) && (in_sym <= NS);
        c_d   = add_mod(in_sym - SW'(1), pos);
`ifdef ROTOR_RING_EN
        c_d   = sub_mod(c_d, ring);
`endif
        // Keep the table index in range for out-of-range symbols.
        if (!in_ok) c_d = '0;
    end

    always_comb begin
        w_s2 = s1_dir ? inv_tbl[s1_c] : fwd_tbl[s1_c];
        o_s2 = sub_mod(w_s2, s1_pos);
`ifdef ROTOR_RING_EN
        o_s2 = add_mod(o_s2, s1_ring);
`endif
        sym_d = s1_err ? '0 : o_s2 + SW'(1);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_valid  <= 1'b0;
            s1_err    <= 1'b0;
            s1_dir    <= 1'b0;
            s1_c      <= '0;
            s1_pos    <= '0;
`ifdef ROTOR_RING_EN
            s1_ring   <= '0;
`endif
            out_valid <= 1'b0;
            out_sym   <= '0;
            out_err   <= 1'b0;
        end else begin
            s1_valid  <= in_valid;
            s1_err    <= !in_ok;
            s1_dir    <= in_dir;
            s1_c      <= c_d;
            s1_pos    <= pos;
`ifdef ROTOR_RING_EN
            s1_ring   <= ring;
`endif
            out_valid <= s1_valid;
            out_sym   <= s1_valid ? sym_d : '0;
            out_err   <= s1_valid & s1_err;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < N_SYM; i++) begin
                fwd_tbl[i] <= SW'(i);
                inv_tbl[i] <= SW'(i);
            end
        end else if (wr_en && (wr_addr < NS) && (wr_data < NS)) begin
            fwd_tbl[wr_addr] <= wr_data;
            inv_tbl[wr_data] <= wr_addr;
        end
    end

    // A rejected pos_load still blocks the step; carry only follows a real step.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pos   <= '0;
            carry <= 1'b0;
        end else begin
            carry <= step && !pos_load && (pos == NOTCH_P);
            if (pos_load) begin
                if (pos_val < NS) pos <= pos_val;
            end else if (step) begin
                pos <= (pos == LAST) ? '0 : pos + SW'(1);
            end
        end
    end

endmodule

// File: tb/tb_rotor_stage.sv
// Self-checking bench for rotor_stage: scoreboard queue of expected {err,sym}
// filled by driver tasks and drained by an output monitor.
module tb_rotor_stage;

    localparam int N     = 26;
    localparam int SW    = 5;
    localparam int NOTCH = 4;
    localparam int W     = SW + 1;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          in_valid = 1'b0;
    logic [SW-1:0] in_sym = '0;
    logic          in_dir = 1'b0;
    logic          out_valid;
    logic [SW-1:0] out_sym;
    logic          out_err;
    logic          step = 1'b0;
    logic          pos_load = 1'b0;
    logic [SW-1:0] pos_val = '0;
    logic [SW-1:0] pos;
    logic          carry;
    logic          wr_en = 1'b0;
    logic [SW-1:0] wr_addr = '0;
    logic [SW-1:0] wr_data = '0;
`ifdef ROTOR_RING_EN
    logic [SW-1:0] ring = '0;
`endif

    rotor_stage #(.N_SYM(N), .SW(SW), .NOTCH(NOTCH)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_sym(in_sym), .in_dir(in_dir),
        .out_valid(out_valid), .out_sym(out_sym), .out_err(out_err),
        .step(step), .pos_load(pos_load), .pos_val(pos_val),
        .pos(pos), .carry(carry),
        .wr_en(wr_en), .wr_addr(wr_addr),
`ifdef ROTOR_RING_EN
        .ring(ring),
`endif
        .wr_data(wr_data)
    );

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    // ---------------- model state ----------------
    int m_fwd [N];
    int m_inv [N];
    int m_pos  = 0;
    int m_ring = 0;

    int n_checks = 0;
    int n_pass   = 0;

    logic [W-1:0] exp_q[$];
    int run_len = 0;
    int max_run = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    endtask

    task automatic model_reset();
        for (int i = 0; i < N; i++) begin
            m_fwd[i] = i;
            m_inv[i] = i;
        end
        m_pos = 0;
    endtask

    function automatic logic [W-1:0] model(input int sym, input int dir, input int p, input int r);
        int c, w, o;
        if (sym < 1 || sym > N) return {1'b1, {SW{1'b0}}};
        c = ((sym - 1 + p - r) % N + N) % N;
        w = dir ? m_inv[c] : m_fwd[c];
        o = ((w - p + r) % N + N) % N;
        return {1'b0, SW'(o + 1)};
    endfunction

    // ---------------- scoreboard monitor ----------------
    always @(negedge clk) begin
        if (!rst && out_valid) begin
            run_len++;
            if (run_len > max_run) max_run = run_len;
            if (exp_q.size() == 0) begin
                check("spurious_out", {26'd0, out_err, out_sym}, 32'hffff_ffff);
            end else begin
                check("out", {26'd0, out_err, out_sym}, {26'd0, exp_q.pop_front()});
            end
        end else begin
            run_len = 0;
        end
    end

    // ---------------- driver tasks ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic next_pos(input bit stp);
        if (stp) m_pos = (m_pos == N - 1) ? 0 : m_pos + 1;
    endtask

    task automatic send(input int sym, input int dir, input bit stp);
        in_valid = 1'b1;
        in_sym   = SW'(sym);
        in_dir   = dir[0];
        step     = stp;
        exp_q.push_back(model(sym, dir, m_pos, m_ring));
        tick();
        in_valid = 1'b0;
        step     = 1'b0;
        next_pos(stp);
    endtask

    task automatic send_lit(input int sym, input int dir, input int exp_sym, input bit stp);
        in_valid = 1'b1;
        in_sym   = SW'(sym);
        in_dir   = dir[0];
        step     = stp;
        exp_q.push_back({1'b0, SW'(exp_sym)});
        tick();
        in_valid = 1'b0;
        step     = 1'b0;
        next_pos(stp);
    endtask

    task automatic write_entry(input int a, input int d);
        wr_en   = 1'b1;
        wr_addr = SW'(a);
        wr_data = SW'(d);
        tick();
        wr_en = 1'b0;
        if (a < N && d < N) begin
            m_fwd[a] = d;
            m_inv[d] = a;
        end
    endtask

    task automatic load_pos(input int v);
        pos_load = 1'b1;
        pos_val  = SW'(v);
        tick();
        pos_load = 1'b0;
        if (v < N) m_pos = v;
        check("load_pos", {27'd0, pos}, m_pos);
        check("load_carry", {31'd0, carry}, 0);
    endtask

    task automatic do_step();
        int pre;
        pre  = m_pos;
        step = 1'b1;
        tick();
        step = 1'b0;
        next_pos(1'b1);
        check("step_pos", {27'd0, pos}, m_pos);
        check("step_carry", {31'd0, carry}, (pre == NOTCH) ? 1 : 0);
    endtask

    // ---------------- stimulus ----------------
    string wiring = "AJDKSIRUXBLHWTMCQGZNPYFVOE";

    initial begin
        model_reset();
        idle(3);
        check("rst_out_valid", {31'd0, out_valid}, 0);
        check("rst_out_sym", {27'd0, out_sym}, 0);
        check("rst_out_err", {31'd0, out_err}, 0);
        check("rst_pos", {27'd0, pos}, 0);
        check("rst_carry", {31'd0, carry}, 0);
        rst = 1'b0;
        tick();

        // identity table
        send_lit(1, 0, 1, 1'b0);
        send_lit(26, 0, 26, 1'b0);
        idle(3);

`ifdef ROTOR_RING_EN
        ring   = SW'(1);
        m_ring = 1;
        send_lit(2, 0, 2, 1'b0);
        send(7, 1, 1'b0);
        idle(3);
        ring   = '0;
        m_ring = 0;
`endif

        // rotor II wiring
        for (int i = 0; i < N; i++) write_entry(i, int'(wiring[i]) - 65);
        send_lit(2, 0, 10, 1'b0);
        send_lit(10, 1, 2, 1'b0);
        send_lit(1, 0, 1, 1'b0);
        idle(3);

        do_step();
        send_lit(1, 0, 9, 1'b0);
        idle(3);
        load_pos(0);
        send_lit(2, 0, 10, 1'b1);
        check("pos_after_step_send", {27'd0, pos}, 1);
        idle(3);

        // position and carry
        load_pos(4);
        do_step();
        tick();
        check("carry_one_cycle", {31'd0, carry}, 0);
        load_pos(25);
        do_step();
        load_pos(30);

        // held step: exactly one carry per pass through the notch
        load_pos(0);
        step = 1'b1;
        for (int i = 0; i < N; i++) begin
            int pre;
            pre = m_pos;
            tick();
            next_pos(1'b1);
            check("held_carry", {31'd0, carry}, (pre == NOTCH) ? 1 : 0);
        end
        step = 1'b0;
        check("held_pos", {27'd0, pos}, m_pos);

        // out-of-range writes are dropped
        write_entry(30, 3);
        write_entry(3, 30);

        // back-to-back stream
        load_pos(7);
        idle(3);
        max_run = 0;
        for (int i = 1; i <= N; i++) send(i, 0, 1'b0);
        for (int i = 1; i <= N; i++) send(i, 1, 1'b0);
        idle(3);
        check("stream_run", max_run, 52);

        // invalid symbols
        send(0, 0, 1'b0);
        send(27, 1, 1'b0);
        idle(3);

        // random traffic, including a partial (non-permutation) table load
        write_entry(0, 5);
        for (int i = 0; i < 40; i++)
            send($urandom_range(0, 27), $urandom_range(0, 1), ($urandom_range(0, 3) == 0));
        idle(3);

        // reset mid-stream
        send(3, 0, 1'b0);
        send(4, 0, 1'b0);
        rst = 1'b1;
        #1;
        check("midrst_out_valid", {31'd0, out_valid}, 0);
        check("midrst_pos", {27'd0, pos}, 0);
        exp_q.delete();
        model_reset();
        tick();
        rst = 1'b0;
        tick();
        send(5, 0, 1'b0);
        send(2, 0, 1'b0);
        send(9, 1, 1'b0);
        idle(4);

        check("drain", exp_q.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/rotor_stage.md
# rotor_stage

Parametrised, pipelined Enigma rotor stage with forward and inverse paths in one block, a runtime-loadable wiring table, and its own stepping position counter with notch carry. Replaces the fixed-wiring, combinational per-rotor inverse modules. Instances chain in the scrambler: each stage's carry drives the next stage's step, and the reflector's output re-enters the stages in inverse mode.

## Interface
- N_SYM, 26, alphabet size; symbols are encoded 1..N_SYM, and 0 means invalid/none.
- SW, 5, symbol/position width; requires N_SYM+1 <= 2^SW.
- NOTCH, 4, 0-based position at which a step produces a carry.
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous reset, active-high.
- in_valid  in  1  input symbol valid this cycle.
- in_sym  in  SW  input symbol, 1..N_SYM.
- in_dir  in  1  0 = forward (entry→reflector), 1 = inverse (reflector→entry).
- out_valid  out  1  output symbol valid.
- out_sym  out  SW  substituted symbol, 1..N_SYM; 0 on error.
- out_err  out  1  input symbol was out of range.
- step  in  1  advance position by one.
- pos_load  in  1  load position from pos_val.
- pos_val  in  SW  position to load, 0..N_SYM-1.
- pos  out  SW  current position, 0-based.
- carry  out  1  one-cycle turnover pulse to the next stage.
- wr_en  in  1  wiring-table write.
- wr_addr  in  SW  contact index, 0..N_SYM-1.
- wr_data  in  SW  wired contact, 0..N_SYM-1.
- ring  in  SW  ring setting, 0..N_SYM-1; present only with ROTOR_RING_EN.

## Operation
- Tables: fwd[N_SYM] and inv[N_SYM], SW bits per entry.
  - Reset loads identity: fwd[i] = inv[i] = i.
  - A write sets fwd[wr_addr] = wr_data and inv[wr_data] = wr_addr on the same edge.
  - A write with wr_addr >= N_SYM or wr_data >= N_SYM is ignored.
  - Loading a full permutation is the controller's job. After a partial load, the inverse path returns whatever inv entries currently hold.
- Mapping, all modulo N_SYM, with r = ring (0 if not compiled):
  - c = (in_sym - 1 + pos - r) mod N.
  - w = fwd[c] when in_dir = 0, or inv[c] when in_dir = 1.
  - out_sym = ((w - pos + r) mod N) + 1.
- Arithmetic: every operand is < N_SYM, so each add or subtract is done in SW+1 bits followed by a single conditional correction (subtract N or add N). No divider.
- Invalid input (in_sym = 0 or in_sym > N_SYM):
  - The item still flows through the pipe.
  - out_valid = 1, out_err = 1, out_sym = 0.
- Position counter:
  - step: pos <= (pos == N_SYM-1) ? 0 : pos + 1.
  - pos_load: pos <= pos_val. A pos_val >= N_SYM is ignored, and pos is held.
  - pos_load has priority over step when both are asserted.
- Carry:
  - Registered. Asserted for exactly one cycle, the cycle after a step edge at which pos was NOTCH before the step.
  - pos_load never generates carry.
  - Held steps give one carry per pass through NOTCH.

## Timing
- Reset values:
  - out_valid = 0, out_sym = 0, out_err = 0.
  - pos = 0, carry = 0.
  - Tables set to identity.
  - Pipeline valid bits cleared.
- Two-stage pipeline, latency 2, throughput 1 symbol/cycle, no backpressure.
- S1, edge ending cycle t:
  - Registers c, dir, the error flag and the current pos.
  - The lookup uses pos before any step or pos_load in the same cycle.
- S2, edge ending cycle t+1:
  - Table read and output formation; out_* are valid in cycle t+2.
  - A table write whose edge ends cycle t is visible to an item in S2 during cycle t+1.
- out_valid is simply the in_valid delayed by 2. Bubbles propagate.
- Reset mid-operation: in-flight items are discarded and out_valid drops immediately (asynchronous). The table returns to identity.

## Configuration
- ROTOR_RING_EN:
  - Defined: the ring port exists and is applied as above. It is sampled in S1 with the item and carried to S2.
  - Undefined: the ring port is absent, r is fixed at 0, and the subtract/add stages are removed.

## Test plan
- Reset, pos 0, identity table; forward in_sym 1 and 26 → out_sym 1 and 26 two cycles later; out_err 0.
- Load rotor II wiring AJDKSIRUXBLHWTMCQGZNPYFVOE (26 writes), pos 0:
  - forward 2 → 10.
  - inverse 10 → 2.
  - forward 1 → 1.
- Same table, step once (pos 1), forward 1: c = 1, w = 9 → out_sym 9. Assert step and in_valid together at pos 0, forward 2 → 10 (pre-step pos used).
- Position and carry:
  - pos_load 4, then step → pos 5 with carry high for exactly one cycle.
  - pos 25, step → pos 0, no carry.
  - pos_load 30 → pos unchanged.
- Back-to-back inputs every cycle: 26 forward symbols then 26 inverse symbols → 52 consecutive out_valid cycles, each output correct. in_sym 0 → out_err 1, out_sym 0.
- With ROTOR_RING_EN, identity table, ring 1, pos 0, forward 2 → 2. Assert rst mid-stream → out_valid 0 at once, and subsequent output follows identity.
